// File: rtl/aclk_pkg.sv
// Shared types and helpers for the alarm-clock keypad/mode controller.
package aclk_pkg;

  localparam logic [3:0] NO_KEY_DEF = 4'd10;
  localparam int         MAX_ALARMS = 32;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    SHOW_ALARM       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  // Callers slice the low NUM_ALARMS bits of the result.
  function automatic logic [MAX_ALARMS-1:0] onehot(input int unsigned idx);
    logic [MAX_ALARMS-1:0] oh;
    oh = '0;
    if (idx < MAX_ALARMS) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/aclk_multi_controller_if.sv
// Keypad/button side and register-strobe side of the controller.
interface aclk_multi_controller_if #(
  parameter int NUM_ALARMS = 4,
  parameter int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int DIGITS     = 4
);
  localparam int DCW = $clog2(DIGITS + 1);

  logic                  one_second;
  logic                  alarm_button;
  logic                  time_button;
  logic [SEL_W-1:0]      alarm_sel;
  logic [3:0]            key;

  logic                  shift;
  logic                  show_new_time;
  logic [NUM_ALARMS-1:0] show_a;
  logic [NUM_ALARMS-1:0] load_new_a;
  logic                  load_new_c;
  logic                  reset_count;
  logic [SEL_W-1:0]      alarm_idx;
  logic [DCW-1:0]        digit_count;

  modport master (
    output one_second, alarm_button, time_button, alarm_sel, key,
    input  shift, show_new_time, show_a, load_new_a, load_new_c,
           reset_count, alarm_idx, digit_count
  );

  modport slave (
    input  one_second, alarm_button, time_button, alarm_sel, key,
    output shift, show_new_time, show_a, load_new_a, load_new_c,
           reset_count, alarm_idx, digit_count
  );
endinterface

// File: rtl/aclk_timeout_timer.sv
// Counts one_second pulses while run is high; fires on the TIMEOUT_SEC-th pulse.
module aclk_timeout_timer #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  input  logic one_second,
  output logic timeout
);
  localparam int            CW   = $clog2(TIMEOUT_SEC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_SEC - 1);

  logic [CW-1:0] cnt;

  // Never wraps: reaching LAST with a pulse always moves the FSM out of run.
  always_ff @(posedge clk) begin
    if (rst || !run || restart) cnt <= '0;
    else if (one_second)        cnt <= cnt + CW'(1);
  end

  assign timeout = run && one_second && (cnt == LAST);
endmodule

// File: rtl/aclk_multi_controller.sv
// Keypad/mode FSM for a multi-alarm clock: digit entry, alarm show/commit, time commit.
module aclk_multi_controller
  import aclk_pkg::*;
#(
  parameter int         NUM_ALARMS  = 4,
  parameter int         SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         DIGITS      = 4,
  parameter logic [3:0] NO_KEY      = NO_KEY_DEF
) (
  input logic                   clk,
  input logic                   rst,
  aclk_multi_controller_if.slave bus
);
  localparam int             DCW = $clog2(DIGITS + 1);
  localparam logic [31:0]    NA  = NUM_ALARMS;
  localparam logic [DCW-1:0] DMX = DCW'(DIGITS);

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      idx_q;
  logic [DCW-1:0]        dc_q;
  logic                  latch_idx;
  logic                  timeout, run, restart;
  logic                  sel_ok, key_hit, dc_full;
  logic [MAX_ALARMS-1:0] oh;

  assign sel_ok  = 32'(bus.alarm_sel) < NA;
  assign key_hit = bus.key != NO_KEY;
  assign dc_full = dc_q == DMX;
  assign run     = (state == KEY_WAITED) || (state == KEY_ENTRY);
  // Each inactivity window is measured from entry into its own state.
  assign restart = (state == KEY_WAITED) && (state_nxt == KEY_ENTRY);

  aclk_timeout_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .restart    (restart),
    .one_second (bus.one_second),
    .timeout    (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW_TIME;
      idx_q <= '0;
      dc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_idx) idx_q <= bus.alarm_sel;
      if (state == SHOW_TIME)                 dc_q <= '0;
      else if (state == KEY_STORED && !dc_full) dc_q <= dc_q + DCW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    latch_idx = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (bus.alarm_button && sel_ok) begin
          state_nxt = SHOW_ALARM;
          latch_idx = 1'b1;
        end else if (key_hit) begin
          state_nxt = KEY_STORED;
        end
      end
      SHOW_ALARM: if (!bus.alarm_button) state_nxt = SHOW_TIME;
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (timeout)       state_nxt = SHOW_TIME;
        else if (!key_hit) state_nxt = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        // A held key with a full buffer blocks the commit buttons too.
        if (timeout) begin
          state_nxt = SHOW_TIME;
        end else if (key_hit) begin
          if (!dc_full) state_nxt = KEY_STORED;
        end else if (bus.alarm_button && sel_ok) begin
          state_nxt = SET_ALARM_TIME;
          latch_idx = 1'b1;
        end else if (bus.time_button) begin
          state_nxt = SET_CURRENT_TIME;
        end
      end
      SET_ALARM_TIME, SET_CURRENT_TIME: state_nxt = SHOW_TIME;
      default: state_nxt = SHOW_TIME;
    endcase
  end

  assign oh                = onehot(32'(idx_q));
  assign bus.shift         = state == KEY_STORED;
  assign bus.show_new_time = (state == KEY_STORED) || (state == KEY_WAITED) ||
                             (state == KEY_ENTRY);
  assign bus.show_a        = (state == SHOW_ALARM)     ? oh[NUM_ALARMS-1:0] : '0;
  assign bus.load_new_a    = (state == SET_ALARM_TIME) ? oh[NUM_ALARMS-1:0] : '0;
  assign bus.load_new_c    = state == SET_CURRENT_TIME;
  assign bus.reset_count   = state == SET_CURRENT_TIME;
  assign bus.alarm_idx     = idx_q;
  assign bus.digit_count   = dc_q;
endmodule

// File: tb/tb_aclk_multi_controller.sv
// Directed-vector bench for aclk_multi_controller (4 alarms, 3-bit select, 10 s timeout).
module tb_aclk_multi_controller;
  import aclk_pkg::*;

  localparam int         NA  = 4;
  localparam int         SW  = 3;
  localparam int         TO  = 10;
  localparam int         DG  = 4;
  localparam logic [3:0] NK  = 4'd10;

  logic gclk = 1'b0;
  logic rst;
  int   n_chk = 0, n_pass = 0;
  int   n_shift = 0, n_lc = 0, n_la = 0;
  int   s0, c0;

  always #5 gclk = ~gclk;

  aclk_multi_controller_if #(.NUM_ALARMS(NA), .SEL_W(SW), .DIGITS(DG)) bus ();

  aclk_multi_controller #(
    .NUM_ALARMS(NA), .SEL_W(SW), .TIMEOUT_SEC(TO), .DIGITS(DG), .NO_KEY(NK)
  ) dut (
    .clk (gclk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge gclk) begin
    if (bus.shift)       n_shift++;
    if (bus.load_new_c)  n_lc++;
    if (|bus.load_new_a) n_la++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  task automatic clr_in();
    bus.one_second = 1'b0; bus.alarm_button = 1'b0; bus.time_button = 1'b0;
    bus.alarm_sel  = '0;   bus.key = NK;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_in(); step(2); rst = 1'b0;
  endtask

  // Press, hold one extra cycle, release: ends in KEY_ENTRY when accepted.
  task automatic digit(input logic [3:0] k);
    bus.key = k; step(2); bus.key = NK; step();
  endtask

  task automatic pulse(input int n);
    repeat (n) begin bus.one_second = 1'b1; step(); bus.one_second = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_in();
    @(negedge gclk);
    do_reset();

    // reset state
    chk("rst_shift", 32'(bus.shift), 0);
    chk("rst_snt",   32'(bus.show_new_time), 0);
    chk("rst_oneh",  32'({bus.show_a, bus.load_new_a}), 0);
    chk("rst_lc",    32'({bus.load_new_c, bus.reset_count}), 0);
    chk("rst_idx",   32'(bus.alarm_idx), 0);
    chk("rst_dc",    32'(bus.digit_count), 0);

    // single key
    s0 = n_shift;
    bus.key = 4'd3; step();
    chk("k1_shift", 32'(bus.shift), 1);
    chk("k1_snt",   32'(bus.show_new_time), 1);
    bus.key = NK; step();
    chk("k1_shift_off", 32'(bus.shift), 0);
    chk("k1_dc",        32'(bus.digit_count), 1);
    step();
    chk("k1_npulse", 32'(n_shift - s0), 1);

    // digit limit
    do_reset();
    s0 = n_shift;
    for (int d = 1; d <= 4; d++) digit(4'(d));
    bus.key = 4'd5; step();
    chk("lim_no_shift", 32'(bus.shift), 0);
    bus.key = NK; step();
    chk("lim_npulse", 32'(n_shift - s0), 4);
    chk("lim_dc",     32'(bus.digit_count), 4);
    chk("lim_snt",    32'(bus.show_new_time), 1);
    bus.time_button = 1'b1; step();
    chk("lim_lc", 32'({bus.load_new_c, bus.reset_count}), 32'b11);
    bus.time_button = 1'b0; step();
    chk("lim_lc_off", 32'(bus.load_new_c), 0);
    step();
    chk("lim_dc_clr", 32'(bus.digit_count), 0);

    // alarm commit and show
    do_reset();
    digit(4'd9); digit(4'd8);
    bus.alarm_sel = 3'd2; bus.alarm_button = 1'b1; step();
    chk("al_load", 32'(bus.load_new_a), 32'b0100);
    chk("al_idx",  32'(bus.alarm_idx), 2);
    bus.alarm_button = 1'b0; step();
    chk("al_load_off", 32'(bus.load_new_a), 0);
    chk("al_snt_off",  32'(bus.show_new_time), 0);
    bus.alarm_button = 1'b1; step();
    chk("show_a", 32'(bus.show_a), 32'b0100);
    bus.alarm_sel = 3'd0; step(2);
    chk("show_a_held", 32'(bus.show_a), 32'b0100);
    bus.alarm_button = 1'b0; step();
    chk("show_a_off", 32'(bus.show_a), 0);

    // both buttons: alarm wins; out-of-range select falls through to time
    do_reset();
    digit(4'd1);
    bus.alarm_sel = 3'd1; bus.alarm_button = 1'b1; bus.time_button = 1'b1; step();
    chk("both_la", 32'(bus.load_new_a), 32'b0010);
    chk("both_lc", 32'(bus.load_new_c), 0);
    bus.alarm_button = 1'b0; bus.time_button = 1'b0; step();
    chk("both_done", 32'(bus.load_new_a), 0);
    digit(4'd6);
    bus.alarm_sel = 3'd5; bus.alarm_button = 1'b1; bus.time_button = 1'b1; step();
    chk("oor_lc",  32'({bus.load_new_c, bus.reset_count}), 32'b11);
    chk("oor_la",  32'(bus.load_new_a), 0);
    chk("oor_idx", 32'(bus.alarm_idx), 1);
    bus.time_button = 1'b0; step();
    chk("oor_show_ign", 32'(bus.show_a), 0);
    bus.alarm_button = 1'b0; step();

    // timeout in KEY_ENTRY
    do_reset();
    digit(4'd1);
    pulse(9);
    chk("to_ke9",  32'(bus.show_new_time), 1);
    pulse(1);
    chk("to_ke10", 32'(bus.show_new_time), 0);

    // timeout with key held in KEY_WAITED
    do_reset();
    bus.key = 4'd7; step(2);
    pulse(9);
    chk("to_kw9",       32'(bus.show_new_time), 1);
    chk("to_kw9_shift", 32'(bus.shift), 0);
    pulse(1);
    bus.key = NK;
    chk("to_kw10", 32'(bus.show_new_time), 0);

    // key coincident with timeout is discarded
    do_reset();
    digit(4'd1);
    pulse(9);
    s0 = n_shift;
    bus.key = 4'd5; bus.one_second = 1'b1; step();
    bus.key = NK; bus.one_second = 1'b0;
    chk("co_shift", 32'(bus.shift), 0);
    chk("co_snt",   32'(bus.show_new_time), 0);
    step(2);
    chk("co_npulse", 32'(n_shift - s0), 0);

    // reset during entry abandons it without strobes
    do_reset();
    digit(4'd2);
    c0 = n_lc;
    bus.time_button = 1'b1; rst = 1'b1; step();
    chk("rk_snt", 32'(bus.show_new_time), 0);
    chk("rk_lc",  32'(bus.load_new_c), 0);
    rst = 1'b0; bus.time_button = 1'b0; step(2);
    chk("rk_nlc", 32'(n_lc - c0), 0);
    chk("rk_dc",  32'(bus.digit_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aclk_multi_controller.md
Name: aclk_multi_controller

Overview:
Next-generation alarm-clock keypad/mode controller. It supports NUM_ALARMS independently settable alarms and a parametrised inactivity timeout. A digit-count limit prevents keypad over-entry. It sits between the keypad scanner/debounced buttons and the key shift register, alarm registers and time counter, and drives their load/shift/display-select strobes.

Parameters:
NUM_ALARMS, 4, number of alarm registers addressed; must be ≥1.
SEL_W, $clog2(NUM_ALARMS) (min 1), width of the alarm select.
TIMEOUT_SEC, 10, seconds of keypad inactivity before abandoning entry; must be ≥2.
DIGITS, 4, maximum digits accepted per entry.
NO_KEY, 10, key code meaning "no key pressed".

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
one_second  in  1  one-clk pulse per second.
alarm_button  in  1  level; show alarm, or commit entry to the selected alarm.
time_button  in  1  level; commit entry to the current time.
alarm_sel  in  SEL_W  alarm index for show/commit.
key  in  4  keypad code; NO_KEY when idle.
shift  out  1  one-cycle strobe: shift key into the entry register.
show_new_time  out  1  display the entry buffer.
show_a  out  NUM_ALARMS  one-hot display select of the latched alarm.
load_new_a  out  NUM_ALARMS  one-hot one-cycle load strobe for the latched alarm.
load_new_c  out  1  one-cycle load strobe for the current time.
reset_count  out  1  one-cycle clear of the seconds prescaler; coincides with load_new_c.
alarm_idx  out  SEL_W  latched alarm index.
digit_count  out  $clog2(DIGITS+1)  digits accepted in the current entry.

Behaviour:
- All registers update on posedge clk. When rst=1 at an edge:
  - state=SHOW_TIME; timer, digit_count and alarm_idx are 0.
  - All outputs are 0 from the following cycle.
- Outputs are Moore decodes of the registered state:
  - shift=(KEY_STORED).
  - show_new_time=(KEY_STORED|KEY_WAITED|KEY_ENTRY).
  - show_a=onehot(alarm_idx) in SHOW_ALARM, else 0.
  - load_new_a=onehot(alarm_idx) in SET_ALARM_TIME, else 0.
  - load_new_c=reset_count=(SET_CURRENT_TIME).
- State transitions:
  - SHOW_TIME:
    - alarm_button & alarm_sel<NUM_ALARMS → SHOW_ALARM, latch alarm_idx=alarm_sel.
    - Else key!=NO_KEY → KEY_STORED.
    - An out-of-range alarm_sel ignores the button.
  - SHOW_ALARM: !alarm_button → SHOW_TIME. alarm_sel changes while held are ignored.
  - KEY_STORED: unconditionally → KEY_WAITED, digit_count+1 (saturating at DIGITS).
  - KEY_WAITED, priority order:
    1. timeout → SHOW_TIME.
    2. key==NO_KEY (key released) → KEY_ENTRY.
    3. Otherwise stay.
  - KEY_ENTRY, priority order:
    1. timeout → SHOW_TIME.
    2. key!=NO_KEY & digit_count<DIGITS → KEY_STORED.
    3. key!=NO_KEY & digit_count==DIGITS → stay; the key is ignored with no shift.
    4. alarm_button & alarm_sel in range → SET_ALARM_TIME, latch alarm_idx.
    5. time_button → SET_CURRENT_TIME.
    6. Otherwise stay.
  - Simultaneous alarm_button and time_button in KEY_ENTRY: alarm wins. Out-of-range alarm_sel there falls through to the time_button check.
  - SET_ALARM_TIME and SET_CURRENT_TIME: one cycle each, then → SHOW_TIME.
- digit_count clears in SHOW_TIME.
- Timeout timer:
  - Counts one_second pulses while in KEY_WAITED or KEY_ENTRY.
  - Clears in every other state and on the KEY_WAITED→KEY_ENTRY transition, so each window is measured from state entry.
  - timeout = (cnt==TIMEOUT_SEC-1) & one_second. The transition takes effect on that edge.
  - This gives exactly TIMEOUT_SEC pulses of inactivity per state; the counter never wraps.
- A key press and timeout in the same cycle: timeout wins and the key is discarded.
- rst mid-entry: no strobe is emitted and the entry is abandoned.

Decomposition:
- Package aclk_pkg holds:
  - the state enum (3 bits: SHOW_TIME=0, KEY_STORED=1, SHOW_ALARM=2, KEY_WAITED=3, KEY_ENTRY=4, SET_ALARM_TIME=5, SET_CURRENT_TIME=6);
  - the NO_KEY default;
  - a onehot helper function.
- Sub-module aclk_timeout_timer: parameter TIMEOUT_SEC; ports clk, rst, run, restart, one_second, timeout.

Test Plan:
- Reset then idle → all outputs 0, state SHOW_TIME; key=3 for 1 cycle → shift high exactly 1 cycle, show_new_time high.
- Enter 1,2,3,4,5 with releases (DIGITS=4) → exactly 4 shift pulses, digit_count=4, fifth key produces no shift.
- Enter 2 digits, alarm_sel=2, alarm_button → load_new_a=4'b0100 for one cycle, then SHOW_TIME; hold alarm_button with alarm_sel=2 → show_a=4'b0100 until release.
- Enter 1 digit, assert alarm_button and time_button in the same cycle → load_new_a pulses, load_new_c stays 0; repeat with alarm_sel=5 (NUM_ALARMS=4) → load_new_c and reset_count pulse together.
- One digit, then 9 one_second pulses → stay in KEY_ENTRY; 10th pulse → SHOW_TIME, show_new_time=0; key held through 10 pulses in KEY_WAITED → SHOW_TIME.
- Key pressed coincident with the 10th one_second pulse → SHOW_TIME, no shift; rst asserted in KEY_ENTRY → SHOW_TIME next cycle, no load strobes.
